snake_frame_buffer: RTL
=======================

Name: snake_frame_buffer

Overview:
Double-buffered 40x30 cell bitmap that sits directly upstream of the VGA controller. Game logic streams the occupied cells (snake body, food, walls) into a back buffer via a valid/ready handshake. The VGA controller reads the front buffer one 40-bit row at a time by driving y_pos and receives the row on VRAM. The buffers swap only during vertical sync, so a half-drawn frame is never displayed.

Parameters:
COLS, 40, cells per row; equals the VRAM width.
ROWS, 30, rows per frame; valid y_pos range is 0..ROWS-1.
XW, 6, width of cell_x.
YW, 5, width of cell_y.

Ports:
clk_25MHz  in  1  pixel clock; the VGA controller uses the same clock domain.
rst_n  in  1  asynchronous, active-low reset.
frame_start  in  1  one-cycle pulse: begin building a new back frame.
frame_done  in  1  one-cycle pulse: the back frame is complete.
cell_valid  in  1  a cell write is offered.
cell_ready  out  1  the block accepts a cell this cycle.
cell_x  in  XW  cell column, 0..COLS-1.
cell_y  in  YW  cell row, 0..ROWS-1.
vga_vs  in  1  VGA_VS from the VGA controller; active low.
y_pos  in  6  row index requested by the VGA controller.
VRAM  out  COLS  front-buffer row for y_pos; bit i is column i; 1 means lit.
busy  out  1  high in any state other than IDLE.
oob_err  out  1  sticky flag: an out-of-range cell was dropped.

Behaviour:
- Storage: two banks, each ROWS x COLS bits. `front_sel` selects the displayed bank; the other bank is the back bank.
- Reset (asynchronous, rst_n=0):
  - both banks all zero, front_sel=0
  - state IDLE, cell_ready=0, busy=0, oob_err=0, VRAM=0
  - vs_q=1
- FSM state IDLE:
  - frame_start=1 -> CLEAR, clr_row=0.
  - frame_done or cell_valid is ignored.
- FSM state CLEAR:
  - Each cycle, zero back-bank row clr_row and increment it.
  - After row ROWS-1 -> DRAW. CLEAR lasts exactly ROWS (30) cycles.
  - cell_ready=0 throughout.
- FSM state DRAW:
  - cell_ready=1.
  - On cell_valid & cell_ready:
    - if cell_x<COLS and cell_y<ROWS, set back[cell_y][cell_x]=1 at the clock edge;
    - otherwise drop the write and set oob_err=1. oob_err stays set until reset.
  - A cell written twice stays 1; this is idempotent.
  - frame_done=1 -> WAIT_SWAP. A cell handshake in the same cycle is still committed.
  - cell_ready drops to 0 the cycle after frame_done.
- FSM state WAIT_SWAP:
  - cell_ready=0.
  - vs_q is vga_vs registered once. vs_fall = vs_q & ~vga_vs.
  - On vs_fall: toggle front_sel -> IDLE. The new front becomes visible on the first VRAM update after the toggle.
- frame_start while in CLEAR, DRAW or WAIT_SWAP is ignored; there is no restart mid-frame.
  - If the swap (vs_fall in WAIT_SWAP) coincides with frame_start, the swap happens and frame_start is dropped.
- busy = (state != IDLE).
- Read path:
  - VRAM is registered: VRAM <= (y_pos < ROWS) ? front[y_pos] : 0. Latency is 1 clock from y_pos.
  - The read path is independent of the FSM; the back bank is never read.
- Reset mid-operation: asynchronous return to the reset state above, including the front bank cleared. The display shows blank until the next completed swap.
- Widths:
  - cell_x and cell_y are compared unsigned against COLS and ROWS.
  - clr_row is a YW-bit counter with no wrap beyond ROWS-1.

Decomposition:
- snake_pkg holds:
  - COLS, ROWS, XW, YW;
  - the FSM state encoding IDLE/CLEAR/DRAW/WAIT_SWAP (2-bit);
  - the row-index width shared with the VGA controller and the game logic.
- Sub-module snake_bitmap_bank: one ROWS x COLS bank with ports clear-row (row index + enable), set-bit (x, y, enable) and combinational row read. It is instantiated twice; bank enables are steered by front_sel.
- The FSM, vs edge detect and VRAM register live in the top level.

Test Plan:
- Reset, then sweep y_pos 0..31 -> VRAM=0 for every row; busy=0; cell_ready=0; oob_err=0.
- Draw and swap:
  - Stimulus: frame_start; wait 30 cycles; write cells (3,5), (39,29), (0,0); frame_done; drive a vga_vs falling edge.
  - Required: cell_ready rises exactly 30 cycles after frame_start.
  - Required, y_pos=5: VRAM=40'h00_0000_0008.
  - Required, y_pos=29: VRAM bit39=1 only.
  - Required, y_pos=0: VRAM=40'h1.
  - Required, before the vs edge: VRAM is still 0.
- No tearing:
  - Stimulus: complete a frame but hold vga_vs=1 for 1000 cycles; then drop vga_vs.
  - Required: old front contents on VRAM throughout the hold; busy=1 in WAIT_SWAP; new contents appear after vs_fall, with 1-cycle read latency.
- Second frame:
  - Stimulus: draw only (10,10), then swap.
  - Required: previous cells (3,5) etc. are gone; y_pos=10 gives VRAM=40'h400; all other rows are 0.
- Out of range:
  - Stimulus: write (40,3) and (2,30) in DRAW.
  - Required: no bank change; oob_err=1 and it stays set across later frames until rst_n=0.
- Reset in DRAW:
  - Stimulus: assert rst_n=0 after 2 cell writes.
  - Required: immediate VRAM=0, state IDLE, cell_ready=0.
  - Required: frame_start issued in WAIT_SWAP (before reset) was ignored; busy does not re-enter CLEAR until IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants, FSM encoding and helpers for the snake double-buffered bitmap.
// Also imported by the VGA controller and game logic for the row-index width.
package snake_pkg;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int XW    = 6;
    localparam int YW    = 5;
    localparam int ROW_W = 6;

    localparam logic [XW-1:0]    COLS_X   = XW'(COLS);
    localparam logic [YW-1:0]    ROWS_Y   = YW'(ROWS);
    localparam logic [YW-1:0]    LAST_ROW = YW'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROWS_R   = ROW_W'(ROWS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        DRAW      = 2'd2,
        WAIT_SWAP = 2'd3
    } state_t;

    function automatic logic cell_in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < COLS_X) && (y < ROWS_Y);
    endfunction

endpackage

// File: rtl/snake_bitmap_bank.sv
// One ROWS x COLS bitmap bank with a row clear port, a single-bit set port
// and a combinational row read.
module snake_bitmap_bank
    import snake_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_en,
    input  logic [YW-1:0]   clr_row,
    input  logic            set_en,
    input  logic [XW-1:0]   set_x,
    input  logic [YW-1:0]   set_y,
    input  logic [YW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data
);

    logic [ROWS-1:0][COLS-1:0] bits;

    // The owner never asserts clr_en and set_en together, so their order here is irrelevant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else begin
            if (clr_en) begin
                bits[clr_row] <= '0;
            end
            if (set_en) begin
                bits[set_y][set_x] <= 1'b1;
            end
        end
    end

    assign rd_data = bits[rd_row];

endmodule

// File: rtl/snake_frame_buffer.sv
// Double-buffered 40x30 cell bitmap feeding the VGA controller; the back
// bank is cleared and drawn, then swapped to the front on VGA_VS falling.
module snake_frame_buffer
    import snake_pkg::*;
(
    input  logic             clk_25MHz,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             frame_done,
    input  logic             cell_valid,
    output logic             cell_ready,
    input  logic [XW-1:0]    cell_x,
    input  logic [YW-1:0]    cell_y,
    input  logic             vga_vs,
    input  logic [ROW_W-1:0] y_pos,
    output logic [COLS-1:0]  VRAM,
    output logic             busy,
    output logic             oob_err
);

    state_t          state;
    logic [YW-1:0]   clr_row;
    logic            front_sel;
    logic            vs_q;
    logic            vs_fall;
    logic            clear_en;
    logic            write_en;
    logic [COLS-1:0] row0;
    logic [COLS-1:0] row1;

    assign vs_fall  = vs_q & ~vga_vs;
    assign clear_en = (state == CLEAR);
    assign write_en = (state == DRAW) & cell_valid & cell_ready & cell_in_range(cell_x, cell_y);

    // Writes always target the bank that is not currently displayed.
    snake_bitmap_bank u_bank0 (
        .clk     (clk_25MHz),
        .rst_n   (rst_n),
        .clr_en  (clear_en & front_sel),
        .clr_row (clr_row),
        .set_en  (write_en & front_sel),
        .set_x   (cell_x),
        .set_y   (cell_y),
        .rd_row  (y_pos[YW-1:0]),
        .rd_data (row0)
    );

    snake_bitmap_bank u_bank1 (
        .clk     (clk_25MHz),
        .rst_n   (rst_n),
        .clr_en  (clear_en & ~front_sel),
        .clr_row (clr_row),
        .set_en  (write_en & ~front_sel),
        .set_x   (cell_x),
        .set_y   (cell_y),
        .rd_row  (y_pos[YW-1:0]),
        .rd_data (row1)
    );

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clr_row    <= '0;
            front_sel  <= 1'b0;
            cell_ready <= 1'b0;
            busy       <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= CLEAR;
                        clr_row <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_row == LAST_ROW) begin
                        state      <= DRAW;
                        cell_ready <= 1'b1;
                    end else begin
                        clr_row <= clr_row + 1'b1;
                    end
                end
                DRAW: begin
                    if (cell_valid && cell_ready && !cell_in_range(cell_x, cell_y)) begin
                        oob_err <= 1'b1;
                    end
                    if (frame_done) begin
                        state      <= WAIT_SWAP;
                        cell_ready <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    if (vs_fall) begin
                        front_sel <= ~front_sel;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cell_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Read path runs independently of the FSM and only ever sees the front bank.
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b1;
            VRAM <= '0;
        end else begin
            vs_q <= vga_vs;
            VRAM <= (y_pos < ROWS_R) ? (front_sel ? row1 : row0) : '0;
        end
    end

endmodule
